mul_share_arbiter: RTL and testbench

- Shares one 4x4 unsigned array multiplier (junsignedArrayMultiplier, port order Y, A, B) among NREQ requesters.
- Round-robin arbitration; valid/ready handshake on each request port and on the single response port.
- One-entry registered output stage tags each product with the winning requester index.
- Sits between multiple client datapaths and the multiplier, so only one multiplier instance is built.

---
 rtl/mul_share_arbiter_if.sv | 22 ++
 rtl/mul_share_arbiter.sv | 97 +++++++++
 tb/tb_mul_share_arbiter.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/mul_share_arbiter_if.sv
// mul_share_arbiter_if: request/response bus between NREQ client datapaths and the shared multiplier arbiter.
interface mul_share_arbiter_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [4*NREQ-1:0] req_a;
  logic [4*NREQ-1:0] req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [7:0]        rsp_y;
  logic [IDW-1:0]    rsp_id;
  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_y, rsp_id
  );
  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_y, rsp_id
  );
endinterface

// File: rtl/mul_share_arbiter.sv
// mul_share_arbiter: round-robin sharing of one 4x4 unsigned array multiplier with a tagged one-entry output stage.
// Optional op_count handshake counter is built when MUL_SHARE_STATS_EN is defined.
module junsignedArrayMultiplier (
  output logic [7:0] Y,
  input  logic [3:0] A,
  input  logic [3:0] B
);
  // acc[r] holds the running sum after row r; bit 0 of each row is a final product bit
  logic [3:0][4:0] acc;
  logic [3:1][4:0] cy;
  assign acc[0] = {1'b0, A & {4{B[0]}}};
  for (genvar r = 1; r < 4; r++) begin : g_row
    assign cy[r][0]  = 1'b0;
    assign acc[r][4] = cy[r][4];
    for (genvar c = 0; c < 4; c++) begin : g_col
      logic p;
      assign p             = A[c] & B[r];
      assign acc[r][c]     = acc[r-1][c+1] ^ p ^ cy[r][c];
      assign cy[r][c+1]    = (acc[r-1][c+1] & p) | (cy[r][c] & (acc[r-1][c+1] ^ p));
    end
  end
  assign Y = {acc[3], acc[2][0], acc[1][0], acc[0][0]};
endmodule

module mul_share_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input logic                clk,
  input logic                rst,
  mul_share_arbiter_if.slave bus
`ifdef MUL_SHARE_STATS_EN
  ,
  output logic [15:0]        op_count
`endif
);
  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;
  logic [0:0]     state_q, state_d;
  logic [7:0]     y_q, y_d, mul_y;
  logic [IDW-1:0] id_q, id_d, ptr_q, ptr_d, g, idx;
  logic [3:0]     mul_a, mul_b;
  logic           found, can_accept, xfer;
  always_comb begin
    found = 1'b0;
    g     = '0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = IDW'((int'(ptr_q) + k) % NREQ);
      if (!found && bus.req_valid[idx]) begin
        found = 1'b1;
        g     = idx;
      end
    end
  end
  assign can_accept    = (state_q == EMPTY) || bus.rsp_ready;
  assign xfer          = found && can_accept;
  assign bus.req_ready = xfer ? {{(NREQ-1){1'b0}}, 1'b1} << g : '0;
  assign mul_a         = bus.req_a[{g, 2'b00} +: 4];
  assign mul_b         = bus.req_b[{g, 2'b00} +: 4];
  junsignedArrayMultiplier u_mul (
    .Y (mul_y),
    .A (mul_a),
    .B (mul_b)
  );
  always_comb begin
    state_d = xfer ? FULL : (bus.rsp_ready ? EMPTY : state_q);
    y_d     = xfer ? mul_y : y_q;
    id_d    = xfer ? g : id_q;
    ptr_d   = xfer ? ((g == IDW'(NREQ - 1)) ? '0 : g + 1'b1) : ptr_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      y_q     <= '0;
      id_q    <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
    end
  end
  assign bus.rsp_valid = (state_q == FULL);
  assign bus.rsp_y     = y_q;
  assign bus.rsp_id    = id_q;
`ifdef MUL_SHARE_STATS_EN
  logic [15:0] cnt_q, cnt_d;
  always_comb cnt_d = (state_q == FULL && bus.rsp_ready && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign op_count = cnt_q;
`endif
endmodule

// File: tb/tb_mul_share_arbiter.sv
// tb_mul_share_arbiter: directed and random stimulus checked against a queue-free transaction model of the arbiter.
module tb_mul_share_arbiter;
  localparam int NREQ = 4;
  localparam int IDW  = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  int m_full, m_y, m_id, m_ptr, m_cnt, last_win;
  int rr_order [5] = '{0, 1, 2, 3, 0};
  int rr_prod  [5] = '{2, 4, 6, 8, 2};
  int bnd_a    [3] = '{0, 1, 15};
  int bnd_prod [3] = '{0, 1, 225};
  logic [15:0] op_count;
  always #5 clk = ~clk;
  mul_share_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();
  mul_share_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
`ifdef MUL_SHARE_STATS_EN
    ,
    .op_count (op_count)
`endif
  );
`ifndef MUL_SHARE_STATS_EN
  assign op_count = 16'd0;
`endif

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_req(input int i, input int a, input int b, input bit v);
    bus.req_valid[i]       = v;
    bus.req_a[i*4 +: 4]    = 4'(a);
    bus.req_b[i*4 +: 4]    = 4'(b);
  endtask

  // One clock: compare outputs at negedge against the model, then advance the model at the edge.
  task automatic step();
    int win;
    bit grant;
    @(negedge clk);
    win = -1;
    for (int k = 0; k < NREQ; k++)
      if (win < 0 && bus.req_valid[(m_ptr + k) % NREQ]) win = (m_ptr + k) % NREQ;
    grant = (win >= 0) && (m_full == 0 || bus.rsp_ready);
    chk("req_ready", 16'(bus.req_ready), grant ? 16'(1 << win) : 16'd0);
    chk("rsp_valid", 16'(bus.rsp_valid), 16'(m_full));
    chk("rsp_y",     16'(bus.rsp_y),     16'(m_y));
    chk("rsp_id",    16'(bus.rsp_id),    16'(m_id));
`ifdef MUL_SHARE_STATS_EN
    chk("op_count", op_count, 16'(m_cnt));
`endif
    @(posedge clk);
    last_win = grant ? win : -1;
    if (rst) begin
      m_full = 0; m_y = 0; m_id = 0; m_ptr = 0; m_cnt = 0;
    end else begin
      if (m_full != 0 && bus.rsp_ready && m_cnt < 65535) m_cnt++;
      if (grant) begin
        m_y    = int'(bus.req_a[win*4 +: 4]) * int'(bus.req_b[win*4 +: 4]);
        m_id   = win;
        m_full = 1;
        m_ptr  = (win + 1) % NREQ;
      end else if (bus.rsp_ready) m_full = 0;
    end
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) step();
    rst = 1'b0;
  endtask

  initial begin
    m_full = 0; m_y = 0; m_id = 0; m_ptr = 0; m_cnt = 0; last_win = -1;
    bus.req_valid = '0; bus.req_a = '0; bus.req_b = '0; bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    do_reset(2);
    chk("reset_valid", 16'(bus.rsp_valid), 16'd0);
    chk("reset_y", 16'(bus.rsp_y), 16'd0);
    // single requester
    set_req(0, 3, 5, 1'b1);
    step();
    set_req(0, 0, 0, 1'b0);
    chk("single_valid", 16'(bus.rsp_valid), 16'd1);
    chk("single_y", 16'(bus.rsp_y), 16'd15);
    chk("single_id", 16'(bus.rsp_id), 16'd0);
    step();
    chk("single_drain", 16'(bus.rsp_valid), 16'd0);
    // boundary operands back-to-back from requester 2
    for (int i = 0; i < 3; i++) begin
      set_req(2, bnd_a[i], bnd_a[i], 1'b1);
      step();
      chk("bnd_y", 16'(bus.rsp_y), 16'(bnd_prod[i]));
      chk("bnd_id", 16'(bus.rsp_id), 16'd2);
    end
    set_req(2, 0, 0, 1'b0);
    step();
    // round-robin with everyone requesting
    do_reset(1);
    for (int i = 0; i < NREQ; i++) set_req(i, i + 1, 2, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rr_grant", 16'(last_win), 16'(rr_order[i]));
      chk("rr_y", 16'(bus.rsp_y), 16'(rr_prod[i]));
    end
    bus.req_valid = '0;
    // backpressure
    do_reset(1);
    set_req(0, 3, 3, 1'b1);
    step();
    set_req(0, 0, 0, 1'b0);
    set_req(1, 4, 5, 1'b1);
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_ready", 16'(bus.req_ready), 16'd0);
      chk("bp_y", 16'(bus.rsp_y), 16'd9);
      chk("bp_id", 16'(bus.rsp_id), 16'd0);
    end
    bus.rsp_ready = 1'b1;
    step();
    set_req(1, 0, 0, 1'b0);
    chk("bp_win", 16'(last_win), 16'd1);
    chk("bp_new_y", 16'(bus.rsp_y), 16'd20);
    step();
    chk("bp_no_dup", 16'(bus.rsp_valid), 16'd0);
    // mid-operation reset
    set_req(0, 3, 4, 1'b1);
    bus.rsp_ready = 1'b0;
    step();
    chk("mid_y", 16'(bus.rsp_y), 16'd12);
    set_req(0, 0, 0, 1'b0);
    do_reset(1);
    chk("mid_rst_valid", 16'(bus.rsp_valid), 16'd0);
    chk("mid_rst_y", 16'(bus.rsp_y), 16'd0);
    bus.rsp_ready = 1'b1;
    set_req(0, 2, 2, 1'b1);
    set_req(3, 5, 5, 1'b1);
    step();
    chk("mid_first_win", 16'(last_win), 16'd0);
    set_req(0, 0, 0, 1'b0);
    // random traffic respecting hold-until-ready
    for (int n = 0; n < 600; n++) begin
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      step();
      for (int i = 0; i < NREQ; i++)
        if (last_win == i || !bus.req_valid[i])
          set_req(i, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    end
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    step();
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
